// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: M-op codes,
// sequencer states and the iteration count.
package muldiv_pkg;

    localparam logic [4:0] ALUOP_MUL    = 5'b01000;
    localparam logic [4:0] ALUOP_MULH   = 5'b01001;
    localparam logic [4:0] ALUOP_MULHSU = 5'b01010;
    localparam logic [4:0] ALUOP_MULHU  = 5'b01011;
    localparam logic [4:0] ALUOP_DIV    = 5'b01100;
    localparam logic [4:0] ALUOP_DIVU   = 5'b01101;
    localparam logic [4:0] ALUOP_REM    = 5'b01110;
    localparam logic [4:0] ALUOP_REMU   = 5'b01111;

    localparam int MD_ITER = 32;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_PREP,
        MD_CALC,
        MD_FIX,
        MD_DONE
    } md_state_t;

    function automatic logic is_mop(input logic [4:0] op);
        return op[4:3] == 2'b01;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift registers and shared add/subtract unit for one-bit-per-cycle
// shift-add multiply and restoring divide on unsigned magnitudes.
module muldiv_datapath #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         step,
    input  logic         is_div,
    input  logic [W-1:0] load_a,
    input  logic [W-1:0] load_b,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    logic [W-1:0] acc_reg, acc_next;
    logic [W-1:0] mq_reg, mq_next;
    logic [W-1:0] b_reg;
    logic [W:0]   shifted;
    logic [W:0]   add_a, add_b;
    logic [W+1:0] sum;
    logic [W:0]   mul_sel;

    // Subtraction is a + ~b + 1; the carry out of bit W+1 means "no borrow".
    always_comb begin
        shifted = {acc_reg, mq_reg[W-1]};
        add_a   = is_div ? shifted : {1'b0, acc_reg};
        add_b   = is_div ? ~{1'b0, b_reg} : {1'b0, b_reg};
        sum     = {1'b0, add_a} + {1'b0, add_b} + {{(W+1){1'b0}}, is_div};
        mul_sel = mq_reg[0] ? sum[W:0] : {1'b0, acc_reg};
    end

    always_comb begin
        acc_next = acc_reg;
        mq_next  = mq_reg;
        if (step) begin
            if (is_div) begin
                if (sum[W+1]) begin
                    acc_next = sum[W-1:0];
                    mq_next  = {mq_reg[W-2:0], 1'b1};
                end else begin
                    acc_next = shifted[W-1:0];
                    mq_next  = {mq_reg[W-2:0], 1'b0};
                end
            end else begin
                acc_next = mul_sel[W:1];
                mq_next  = {mul_sel[0], mq_reg[W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            mq_reg  <= '0;
            b_reg   <= '0;
        end else if (init) begin
            acc_reg <= '0;
            mq_reg  <= load_a;
            b_reg   <= load_b;
        end else begin
            acc_reg <= acc_next;
            mq_reg  <= mq_next;
        end
    end

    assign hi = acc_reg;
    assign lo = mq_reg;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: FSM, sign handling, special cases and
// pipeline stall/done signalling around the iterative datapath.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      ALUOP,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    md_state_t         state_reg, state_next;
    logic [4:0]        count_reg, count_next;
    logic [2:0]        op_reg;
    logic [XLEN-1:0]   op1_reg, op2_reg;
    logic              neg_reg, rem_neg_reg;
    logic [XLEN-1:0]   result_next;

    logic              accept, init, step;
    logic              is_div, is_rem, sign1, sign2, neg1, neg2;
    logic [XLEN-1:0]   mag1, mag2, hi, lo;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_result, fix_result;
    logic [2*XLEN-1:0] product, prod_fix;

    assign accept = START & is_mop(ALUOP) & ~FLUSH;

    // op_reg holds ALUOP[2:0]: bit 2 selects divide, bit 0 marks unsigned divide.
    assign is_div = op_reg[2];
    assign is_rem = op_reg[1];
    assign sign1  = is_div ? ~op_reg[0] : (op_reg[1] ^ op_reg[0]);
    assign sign2  = is_div ? ~op_reg[0] : (op_reg[1:0] == 2'b01);
    assign neg1   = sign1 & op1_reg[XLEN-1];
    assign neg2   = sign2 & op2_reg[XLEN-1];
    assign mag1   = neg1 ? -op1_reg : op1_reg;
    assign mag2   = neg2 ? -op2_reg : op2_reg;

    assign div_zero = is_div & (op2_reg == '0);
    assign div_ovf  = is_div & ~op_reg[0] & (op1_reg == {1'b1, {(XLEN-1){1'b0}}}) & (&op2_reg);
    assign special  = div_zero | div_ovf;
    assign special_result = div_zero ? (is_rem ? op1_reg : '1) : (is_rem ? '0 : op1_reg);

    assign product  = {hi, lo};
    assign prod_fix = neg_reg ? -product : product;

    always_comb begin
        fix_result = '0;
        if (is_div) begin
            if (is_rem) fix_result = rem_neg_reg ? -hi : hi;
            else        fix_result = neg_reg ? -lo : lo;
        end else if (op_reg[1:0] == 2'b00) begin
            fix_result = prod_fix[XLEN-1:0];
        end else begin
            fix_result = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        result_next = RESULT;
        init        = 1'b0;
        step        = 1'b0;
        case (state_reg)
            MD_IDLE: if (accept) state_next = MD_PREP;
            MD_PREP: begin
                if (special) begin
                    state_next  = MD_DONE;
                    result_next = special_result;
                end else begin
                    state_next = MD_CALC;
                    count_next = 5'(MD_ITER - 1);
                    init       = 1'b1;
                end
            end
            MD_CALC: begin
                step       = 1'b1;
                count_next = count_reg - 5'd1;
                if (count_reg == 5'd0) state_next = MD_FIX;
            end
            MD_FIX: begin
                state_next  = MD_DONE;
                result_next = fix_result;
            end
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
        // A flushed instruction must leave no architectural trace.
        if (FLUSH) begin
            state_next  = MD_IDLE;
            result_next = RESULT;
            init        = 1'b0;
            step        = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg   <= MD_IDLE;
            count_reg   <= '0;
            op_reg      <= '0;
            op1_reg     <= '0;
            op2_reg     <= '0;
            neg_reg     <= 1'b0;
            rem_neg_reg <= 1'b0;
            RESULT      <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            RESULT    <= result_next;
            if (state_reg == MD_IDLE && accept) begin
                op_reg  <= ALUOP[2:0];
                op1_reg <= OPERAND1;
                op2_reg <= OPERAND2;
            end
            if (init) begin
                neg_reg     <= neg1 ^ neg2;
                rem_neg_reg <= neg1;
            end
        end
    end

    muldiv_datapath #(.W(XLEN)) u_datapath (
        .clk    (CLK),
        .rst    (RESET),
        .init   (init),
        .step   (step),
        .is_div (is_div),
        .load_a (mag1),
        .load_b (mag2),
        .hi     (hi),
        .lo     (lo)
    );

    assign BUSY = ((state_reg == MD_IDLE) & accept)
                | (state_reg == MD_PREP) | (state_reg == MD_CALC) | (state_reg == MD_FIX);
    assign DONE = (state_reg == MD_DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer: an arithmetic reference
// model plus a cycle-timeline scoreboard checked on every falling edge.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET, START, FLUSH;
    logic [4:0]  ALUOP;
    logic [31:0] OPERAND1, OPERAND2;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    muldiv_sequencer #(.XLEN(32)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .ALUOP    (ALUOP),
        .OPERAND1 (OPERAND1),
        .OPERAND2 (OPERAND2),
        .FLUSH    (FLUSH),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .RESULT   (RESULT)
    );

    initial forever #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Expected timeline, written by the stimulus process.
    int          busy_lo   = 0;
    int          busy_hi   = -1;
    int          done_cyc  = -1;
    int          clear_cyc = -1;
    logic [31:0] pend_result = '0;
    bit          lit_on = 1'b0;
    logic [31:0] lit_val = '0;

    // Owned by the compare process.
    logic [31:0] cur_result = '0;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, q;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            ALUOP_MUL:    begin sp = sa * sb; return sp[31:0]; end
            ALUOP_MULH:   begin sp = sa * sb; return sp[63:32]; end
            ALUOP_MULHSU: begin sp = sa * longint'(ub); return sp[63:32]; end
            ALUOP_MULHU:  begin up = ua * ub; return up[63:32]; end
            ALUOP_DIV: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                q = sa / sb; return q[31:0];
            end
            ALUOP_REM: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                q = sa % sb; return q[31:0];
            end
            ALUOP_DIVU: begin
                if (b == 0) return 32'hFFFFFFFF;
                up = ua / ub; return up[31:0];
            end
            ALUOP_REMU: begin
                if (b == 0) return a;
                up = ua % ub; return up[31:0];
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if ((op == ALUOP_DIV || op == ALUOP_DIVU || op == ALUOP_REM || op == ALUOP_REMU) && b == 0)
            return 1'b1;
        if ((op == ALUOP_DIV || op == ALUOP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF)
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (cyc == clear_cyc) cur_result = '0;
        if (cyc == done_cyc) begin
            cur_result = pend_result;
            if (lit_on) begin
                check("model_vs_literal", pend_result, lit_val);
                check("result_literal", RESULT, lit_val);
            end
        end
        check("busy", {31'b0, BUSY}, {31'b0, (cyc >= busy_lo && cyc <= busy_hi)});
        check("done", {31'b0, DONE}, {31'b0, (cyc == done_cyc)});
        check("result", RESULT, cur_result);
    end

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge CLK); #1;
            START = 1'b0; FLUSH = 1'b0; RESET = 1'b0;
            ALUOP = 5'($urandom); OPERAND1 = $urandom; OPERAND2 = $urandom;
        end
    endtask

    // flush_k: -1 none, 0 FLUSH together with START, >0 FLUSH in cycle n+flush_k.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int flush_k, input bit hold, input bit has_lit, input logic [31:0] lit);
        int n, last;
        bit sp;
        @(posedge CLK); #1;
        n = cyc;
        RESET = 1'b0; START = 1'b1; FLUSH = (flush_k == 0);
        ALUOP = op; OPERAND1 = a; OPERAND2 = b;
        sp = is_special(op, a, b);
        pend_result = model(op, a, b);
        lit_on = has_lit && flush_k < 0;
        lit_val = lit;
        if (flush_k == 0) begin
            busy_lo = 0; busy_hi = -1; done_cyc = -1; last = n;
        end else if (flush_k > 0) begin
            busy_lo = n; busy_hi = n + flush_k; done_cyc = -1; last = n + flush_k;
        end else begin
            busy_lo = n; busy_hi = sp ? n + 1 : n + 34; done_cyc = sp ? n + 2 : n + 35;
            last = done_cyc;
        end
        $display("txn cyc=%0d op=%b a=%h b=%h model=%h special=%0d flush_k=%0d hold=%0d",
                 n, op, a, b, pend_result, sp, flush_k, hold);
        for (int c = n + 1; c <= last; c++) begin
            @(posedge CLK); #1;
            if (!hold) begin
                START = 1'b0; ALUOP = 5'($urandom); OPERAND1 = $urandom; OPERAND2 = $urandom;
            end
            if (flush_k > 0 && c == n + flush_k) FLUSH = 1'b1;
        end
    endtask

    task automatic reset_mid(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
        int n;
        @(posedge CLK); #1;
        n = cyc;
        START = 1'b1; FLUSH = 1'b0; RESET = 1'b0; ALUOP = op; OPERAND1 = a; OPERAND2 = b;
        busy_lo = n; busy_hi = n + k - 1; done_cyc = -1; clear_cyc = n + k; lit_on = 1'b0;
        $display("txn cyc=%0d op=%b a=%h b=%h reset_at=%0d", n, op, a, b, n + k);
        for (int c = n + 1; c <= n + k; c++) begin
            @(posedge CLK); #1;
            START = 1'b0;
            if (c == n + k) RESET = 1'b1;
        end
    endtask

    task automatic junk(input int n);
        logic [4:0] op;
        for (int c = 0; c < n; c++) begin
            @(posedge CLK); #1;
            op = 5'($urandom);
            if (op[4:3] == 2'b01) op[4] = 1'b1;
            if (c == 0) op = 5'b00000;
            RESET = 1'b0; FLUSH = 1'b0; START = 1'b1; ALUOP = op;
            OPERAND1 = $urandom; OPERAND2 = $urandom;
            $display("txn cyc=%0d non-M op=%b ignored", cyc, op);
        end
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
        ALUOP = '0; OPERAND1 = '0; OPERAND2 = '0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;

        issue(ALUOP_MUL,    32'd7,        32'hFFFFFFFD, -1, 0, 1, 32'hFFFFFFEB);
        issue(ALUOP_MULH,   32'h80000000, 32'h80000000, -1, 0, 1, 32'h40000000);
        issue(ALUOP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0, 1, 32'hFFFFFFFE);
        issue(ALUOP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0, 1, 32'hFFFFFFFF);
        issue(ALUOP_DIV,    32'hFFFFFFF9, 32'd2,        -1, 0, 1, 32'hFFFFFFFD);
        issue(ALUOP_REM,    32'hFFFFFFF9, 32'd2,        -1, 0, 1, 32'hFFFFFFFF);
        issue(ALUOP_DIVU,   32'd100,      32'd7,        -1, 0, 1, 32'd14);
        issue(ALUOP_REMU,   32'd100,      32'd7,        -1, 0, 1, 32'd2);
        issue(ALUOP_DIV,    32'd5,        32'd0,        -1, 0, 1, 32'hFFFFFFFF);
        issue(ALUOP_REM,    32'd5,        32'd0,        -1, 0, 1, 32'd5);
        issue(ALUOP_DIV,    32'h80000000, 32'hFFFFFFFF, -1, 0, 1, 32'h80000000);
        issue(ALUOP_REM,    32'h80000000, 32'hFFFFFFFF, -1, 0, 1, 32'h0);

        junk(3);
        idle(1);
        issue(ALUOP_MUL, 32'd9, 32'd9, 0, 0, 0, 32'h0);
        idle(2);
        issue(ALUOP_DIVU, 32'd1000, 32'd3, 11, 0, 0, 32'h0);
        issue(ALUOP_DIVU, 32'd1000, 32'd3, -1, 0, 1, 32'd333);
        issue(ALUOP_MUL, 32'd3, 32'd5, -1, 1, 1, 32'd15);
        idle(2);
        reset_mid(ALUOP_MULHU, 32'hDEADBEEF, 32'h12345678, 10);
        issue(ALUOP_REMU, 32'd100, 32'd7, -1, 0, 1, 32'd2);

        for (int i = 0; i < 40; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            int          fk;
            op = {2'b01, 3'($urandom_range(0, 7))};
            a = pick();
            b = pick();
            fk = -1;
            if ($urandom_range(0, 4) == 0) fk = is_special(op, a, b) ? 1 : $urandom_range(1, 34);
            issue(op, a, b, fk, 0, 0, 32'h0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
